// File: rtl/amux_pkg.sv
// Shared types and helpers for the analog-mux scan controller.
package amux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BREAK  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CONV   = 3'd3,
    ST_NEXT   = 3'd4
  } state_e;

  localparam int unsigned BBM_DEFAULT  = 2;
  localparam int unsigned SETW_DEFAULT = 8;
  localparam int unsigned MAX_CH       = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } next_ch_t;

  // Lowest set bit of mask at or above position first (first may be 32 = none).
  function automatic next_ch_t next_set_bit(input logic [31:0] mask, input logic [5:0] first);
    next_ch_t res;
    res.found = 1'b0;
    res.idx   = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i] && (i >= int'(first))) begin
        res.found = 1'b1;
        res.idx   = 5'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/amux_next_ch.sv
// Combinational search for the next enabled channel, either strictly above idx
// or (from_zero=1) the lowest enabled channel overall.
module amux_next_ch
  import amux_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] idx,
  input  logic            from_zero,
  output logic [SELW-1:0] nxt,
  output logic            found
);

  logic [31:0] mask_w;
  logic [5:0]  first;
  next_ch_t    res;

  // Widen to the package search width and run the priority search
  always_comb begin
    mask_w            = 32'd0;
    mask_w[NCH-1:0]   = mask;
    if (from_zero) begin
      first = 6'd0;
    end else begin
      first = {{(6-SELW){1'b0}}, idx} + 6'd1;
    end
    res   = next_set_bit(mask_w, first);
    found = res.found && (int'(res.idx) < NCH);
    nxt   = res.idx[SELW-1:0];
  end

endmodule

// File: rtl/amux_scan_ctrl.sv
// N-channel analog mux scan controller with break-before-make and ADC handshake.
// Optional continuous (wrapping) scan mode: define AMUX_SCAN_CONT_EN.
module amux_scan_ctrl
  import amux_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int SELW = $clog2(NCH),
  parameter int SETW = SETW_DEFAULT,
  parameter int BBM  = BBM_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [NCH-1:0]  ch_mask,
`ifdef AMUX_SCAN_CONT_EN
  input  logic            cont,
`endif
  input  logic [SETW-1:0] settle,
  output logic [NCH-1:0]  sw_en,
  output logic [SELW-1:0] sel,
  output logic            conv_req,
  input  logic            conv_done,
  output logic            ch_done,
  output logic [SELW-1:0] done_ch,
  output logic            busy,
  output logic            scan_done
);

  localparam int BBMW = (BBM > 1) ? $clog2(BBM) : 1;

  state_e          state_q, state_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [SETW-1:0] settle_q, settle_d;
  logic            cont_q, cont_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [BBMW-1:0] bbm_cnt_q, bbm_cnt_d;
  logic [SETW-1:0] set_cnt_q, set_cnt_d;
  logic [NCH-1:0]  sw_en_q, sw_en_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            conv_req_q, conv_req_d;
  logic            ch_done_q, ch_done_d;
  logic [SELW-1:0] done_ch_q, done_ch_d;
  logic            busy_q, busy_d;
  logic            scan_done_q, scan_done_d;

  logic            cont_s;
  logic [NCH-1:0]  search_mask_s;
  logic [NCH-1:0]  onehot_s;
  logic [SELW-1:0] first_idx_s, nxt_idx_s;
  logic            first_found_s, nxt_found_s;

`ifdef AMUX_SCAN_CONT_EN
  assign cont_s = cont;
`else
  assign cont_s = 1'b0;
`endif

  // Lowest-channel search serves both scan start (live mask) and wrap (latched mask)
  assign search_mask_s = (state_q == ST_IDLE) ? ch_mask : mask_q;
  assign onehot_s      = {{(NCH-1){1'b0}}, 1'b1} << ptr_q;

  amux_next_ch #(.NCH(NCH), .SELW(SELW)) u_first (
    .mask      (search_mask_s),
    .idx       (ptr_q),
    .from_zero (1'b1),
    .nxt       (first_idx_s),
    .found     (first_found_s)
  );

  amux_next_ch #(.NCH(NCH), .SELW(SELW)) u_above (
    .mask      (mask_q),
    .idx       (ptr_q),
    .from_zero (1'b0),
    .nxt       (nxt_idx_s),
    .found     (nxt_found_s)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    settle_d    = settle_q;
    cont_d      = cont_q;
    ptr_d       = ptr_q;
    bbm_cnt_d   = bbm_cnt_q;
    set_cnt_d   = set_cnt_q;
    sw_en_d     = sw_en_q;
    sel_d       = sel_q;
    conv_req_d  = conv_req_q;
    ch_done_d   = 1'b0;
    done_ch_d   = done_ch_q;
    scan_done_d = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        sw_en_d    = '0;
        conv_req_d = 1'b0;
        if (start && first_found_s) begin
          mask_d    = ch_mask;
          settle_d  = settle;
          cont_d    = cont_s;
          ptr_d     = first_idx_s;
          bbm_cnt_d = BBMW'(BBM - 1);
          state_d   = ST_BREAK;
        end else if (start) begin
          scan_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BREAK: begin
        sw_en_d = '0;
        if (bbm_cnt_q == '0) begin
          sw_en_d   = onehot_s;
          sel_d     = ptr_q;
          set_cnt_d = settle_q;
          state_d   = ST_SETTLE;
        end else begin
          bbm_cnt_d = bbm_cnt_q - BBMW'(1);
        end
      end
      ST_SETTLE: begin
        if (set_cnt_q == '0) begin
          conv_req_d = 1'b1;
          state_d    = ST_CONV;
        end else begin
          set_cnt_d = set_cnt_q - SETW'(1);
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          conv_req_d = 1'b0;
          sw_en_d    = '0;
          ch_done_d  = 1'b1;
          done_ch_d  = ptr_q;
          state_d    = ST_NEXT;
        end else begin
          conv_req_d = 1'b1;
        end
      end
      ST_NEXT: begin
        // Switches are already open here, so the next BREAK adds BBM more open cycles
        if (nxt_found_s) begin
          ptr_d     = nxt_idx_s;
          bbm_cnt_d = BBMW'(BBM - 1);
          state_d   = ST_BREAK;
        end else if (cont_q) begin
          scan_done_d = 1'b1;
          ptr_d       = first_idx_s;
          bbm_cnt_d   = BBMW'(BBM - 1);
          state_d     = ST_BREAK;
        end else begin
          scan_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        sw_en_d    = '0;
        conv_req_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      sw_en_d     = '0;
      conv_req_d  = 1'b0;
      ch_done_d   = 1'b0;
      scan_done_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      busy_d = (state_d != ST_IDLE);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      settle_q    <= '0;
      cont_q      <= 1'b0;
      ptr_q       <= '0;
      bbm_cnt_q   <= '0;
      set_cnt_q   <= '0;
      sw_en_q     <= '0;
      sel_q       <= '0;
      conv_req_q  <= 1'b0;
      ch_done_q   <= 1'b0;
      done_ch_q   <= '0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      settle_q    <= settle_d;
      cont_q      <= cont_d;
      ptr_q       <= ptr_d;
      bbm_cnt_q   <= bbm_cnt_d;
      set_cnt_q   <= set_cnt_d;
      sw_en_q     <= sw_en_d;
      sel_q       <= sel_d;
      conv_req_q  <= conv_req_d;
      ch_done_q   <= ch_done_d;
      done_ch_q   <= done_ch_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign sw_en     = sw_en_q;
  assign sel       = sel_q;
  assign conv_req  = conv_req_q;
  assign ch_done   = ch_done_q;
  assign done_ch   = done_ch_q;
  assign busy      = busy_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_amux_scan_ctrl.sv
// Self-checking bench for amux_scan_ctrl: timeline model, vector table, corner sequences.
module tb_amux_scan_ctrl;
  localparam int NCH  = 8;
  localparam int SELW = 3;
  localparam int SETW = 8;
  localparam int BBM  = 2;
  localparam int MAXC = 600;

  logic       clk = 1'b0;
  logic       reset, start, abort, conv_done, cont;
  logic [7:0] ch_mask, settle;
  logic [7:0] sw_en;
  logic [2:0] sel, done_ch;
  logic       conv_req, ch_done, busy, scan_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  amux_scan_ctrl #(.NCH(NCH), .SELW(SELW), .SETW(SETW), .BBM(BBM)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .ch_mask   (ch_mask),
`ifdef AMUX_SCAN_CONT_EN
    .cont      (cont),
`endif
    .settle    (settle),
    .sw_en     (sw_en),
    .sel       (sel),
    .conv_req  (conv_req),
    .conv_done (conv_done),
    .ch_done   (ch_done),
    .done_ch   (done_ch),
    .busy      (busy),
    .scan_done (scan_done)
  );

  typedef struct {
    logic [7:0] mask;
    logic [7:0] settle;
    int         dly;
    int         ndone;
    int         t_close;
    int         t_req;
    int         t_sdone;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs with don't-care fields zeroed (sel only while closed, done_ch only on ch_done)
  function automatic logic [31:0] obs();
    return {14'd0, sw_en, (sw_en != 8'd0) ? sel : 3'd0, conv_req, ch_done,
            ch_done ? done_ch : 3'd0, busy, scan_done};
  endfunction

  function automatic logic [31:0] raw();
    return {14'd0, sw_en, sel, conv_req, ch_done, done_ch, busy, scan_done};
  endfunction

  // One single-pass scan; start is applied in the current cycle (cycle 0)
  task automatic run_scan(input logic [7:0] m, input logic [7:0] st, input int dly[8], input bit noise,
                          output int ndone, output int t_close, output int t_req,
                          output int t_sdone, output logic [7:0] done_set);
    int e_sw[MAXC], e_sel[MAXC], e_req[MAXC], e_chd[MAXC], e_dch[MAXC];
    int e_bsy[MAXC], e_sdn[MAXC], e_cd[MAXC];
    int b, close, rise, t, fin;
    logic [31:0] expv;
    for (int c = 0; c < MAXC; c++) begin
      e_sw[c] = 0; e_sel[c] = 0; e_req[c] = 0; e_chd[c] = 0;
      e_dch[c] = 0; e_bsy[c] = 0; e_sdn[c] = 0; e_cd[c] = 0;
    end
    b = 1;
    if (m == 8'h00) begin
      e_sdn[1] = 1;
      fin = 1;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (m[ch]) begin
          close = b + BBM;
          rise  = close + int'(st) + 1;
          t     = rise + dly[ch];
          for (int c = close; c <= t; c++) begin
            e_sw[c]  = 1 << ch;
            e_sel[c] = ch;
          end
          for (int c = rise; c <= t; c++) e_req[c] = 1;
          e_cd[t]      = 1;
          e_chd[t + 1] = 1;
          e_dch[t + 1] = ch;
          b = t + 2;
        end
      end
      for (int c = 1; c < b; c++) e_bsy[c] = 1;
      e_sdn[b] = 1;
      fin = b;
    end
    ndone = 0; t_close = -1; t_req = -1; t_sdone = -1; done_set = 8'd0;
    for (int c = 0; c <= fin + 1; c++) begin
      expv = {14'd0, 8'(e_sw[c]), 3'(e_sel[c]), 1'(e_req[c]), 1'(e_chd[c]),
              3'(e_dch[c]), 1'(e_bsy[c]), 1'(e_sdn[c])};
      check("scan_cycle", c, obs(), expv);
      if (ch_done) begin
        ndone++;
        done_set = done_set | (8'd1 << done_ch);
      end
      if (sw_en != 8'd0 && t_close < 0) t_close = c;
      if (conv_req && t_req < 0) t_req = c;
      if (scan_done && t_sdone < 0) t_sdone = c;
      start     = (c == 0) ? 1'b1 : (noise && (c < fin) && ($urandom_range(0, 3) == 0));
      ch_mask   = (c == 0 || !noise) ? m : 8'($urandom_range(0, 255));
      settle    = (c == 0 || !noise) ? st : 8'($urandom_range(0, 255));
      conv_done = (e_cd[c] != 0) ? 1'b1 : (noise && (e_req[c] == 0) && ($urandom_range(0, 2) == 0));
      abort     = 1'b0;
      tick();
    end
    start = 1'b0; conv_done = 1'b0; ch_mask = 8'd0; settle = 8'd0;
  endtask

  initial begin
    int dly[8];
    int nd, tc, tr, ts;
    logic [7:0] ds, m;

    vecs[0] = '{8'h25, 8'd3, 2, 3, 3, 7, 31};
    vecs[1] = '{8'h00, 8'd3, 2, 0, -1, -1, 1};
    vecs[2] = '{8'h80, 8'd0, 0, 1, 3, 4, 6};
    vecs[3] = '{8'h81, 8'd1, 1, 2, 3, 5, 15};
    vecs[4] = '{8'hFF, 8'd0, 0, 8, 3, 4, 41};

    reset = 1'b1; start = 1'b0; abort = 1'b0; conv_done = 1'b0; cont = 1'b0;
    ch_mask = 8'd0; settle = 8'd0;
    repeat (3) tick();
    check("reset_state", 0, raw(), 32'd0);
    reset = 1'b0;
    tick();

    // Vector table
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 8; k++) dly[k] = vecs[v].dly;
      run_scan(vecs[v].mask, vecs[v].settle, dly, 1'b0, nd, tc, tr, ts, ds);
      check("vec_ndone", v, nd, vecs[v].ndone);
      check("vec_close", v, tc, vecs[v].t_close);
      check("vec_req", v, tr, vecs[v].t_req);
      check("vec_sdone", v, ts, vecs[v].t_sdone);
      check("vec_chset", v, {24'd0, ds}, {24'd0, vecs[v].mask});
    end

    // Randomized scans with ignored-input noise
    for (int r = 0; r < 25; r++) begin
      m = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      for (int k = 0; k < 8; k++) dly[k] = $urandom_range(0, 4);
      run_scan(m, 8'($urandom_range(0, 7)), dly, 1'b1, nd, tc, tr, ts, ds);
      check("rnd_chset", r, {24'd0, ds}, {24'd0, m});
    end

    // Abort in the same cycle as conv_done on channel 2
    start = 1'b1; ch_mask = 8'h04; settle = 8'd1;
    tick(); start = 1'b0;
    tick(); tick();
    check("abort_close", 3, {24'd0, sw_en}, 32'h04);
    tick(); tick();
    check("abort_req", 5, {31'd0, conv_req}, 32'd1);
    tick();
    conv_done = 1'b1; abort = 1'b1;
    tick();
    conv_done = 1'b0; abort = 1'b0;
    check("abort_next", 7, obs(), 32'd0);
    tick();
    check("abort_quiet", 8, obs(), 32'd0);

    // Abort during BREAK
    start = 1'b1; ch_mask = 8'h03; settle = 8'd0;
    tick(); start = 1'b0;
    check("abort_brk_busy", 1, {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick(); abort = 1'b0;
    for (int c = 2; c < 6; c++) begin
      check("abort_brk_idle", c, obs(), 32'd0);
      tick();
    end

    // Reset mid-SETTLE, then a clean scan
    start = 1'b1; ch_mask = 8'h40; settle = 8'd5;
    tick(); start = 1'b0;
    tick(); tick();
    check("rst_close", 3, {21'd0, sw_en, sel}, {21'd0, 8'h40, 3'd6});
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_mid_settle", 6, raw(), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) dly[k] = 1;
    run_scan(8'h41, 8'd2, dly, 1'b0, nd, tc, tr, ts, ds);
    check("rst_clean_ndone", 0, nd, 2);

`ifdef AMUX_SCAN_CONT_EN
    begin : cont_test
      int exp_ch, since, nsd;
      exp_ch = 0; since = 99; nsd = 0;
      cont = 1'b1; start = 1'b1; ch_mask = 8'h03; settle = 8'd0;
      tick(); start = 1'b0; cont = 1'b0;
      for (int c = 1; c < 80; c++) begin
        if (ch_done) begin
          check("cont_order", c, {29'd0, done_ch}, exp_ch);
          exp_ch = 1 - exp_ch;
          since = 0;
        end
        if (scan_done) begin
          check("cont_wrap", c, since, 1);
          check("cont_wrap_ch", c, exp_ch, 0);
          nsd++;
        end
        since++;
        conv_done = conv_req;
        tick();
      end
      conv_done = 1'b0; abort = 1'b1;
      tick(); abort = 1'b0;
      check("cont_abort", 0, {31'd0, busy}, 32'd0);
      check("cont_nsd", 0, (nsd >= 5) ? 1 : 0, 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
